// File: rtl/disp_regctrl_mp_if.sv
`default_nettype none
// ============================================================================
//  Module      : disp_regctrl_mp_if
//  Description : Host register bus for the display register/frame-control
//                block. Byte-enabled single-cycle write channel plus a read
//                channel whose data returns one cycle after RDEN.
//  Revision    : 1.0  initial release
//
//  Signals
//    WRADDR [15:0]  write address
//    BYTEEN [3:0]   byte-lane enables for WDATA
//    WREN           write strobe, one cycle per write
//    WDATA  [31:0]  write data
//    RDADDR [15:0]  read address
//    RDEN           read enable
//    RDATA  [31:0]  registered read data
//
//  Modports
//    master : host side (drives address/data/strobes, receives RDATA)
//    slave  : register block side
// ============================================================================
interface disp_regctrl_mp_if;
  logic [15:0] WRADDR;
  logic [3:0]  BYTEEN;
  logic        WREN;
  logic [31:0] WDATA;
  logic [15:0] RDADDR;
  logic        RDEN;
  logic [31:0] RDATA;

  modport master (
    output WRADDR, BYTEEN, WREN, WDATA, RDADDR, RDEN,
    input  RDATA
  );

  modport slave (
    input  WRADDR, BYTEEN, WREN, WDATA, RDADDR, RDEN,
    output RDATA
  );
endinterface
`default_nettype wire

// File: rtl/disp_regctrl_mp.sv
`default_nettype none
// ============================================================================
//  Module      : disp_regctrl_mp
//  Description : Display register and frame-control block with NUM_PAGES
//                frame-buffer address registers and optional automatic page
//                flipping. The active frame address only changes on a frame
//                start (falling edge of synchronised vsync), so flips never
//                tear.
//  Revision    : 1.0  initial release
//
//  Optional feature macro: DISP_FRAMECNT_EN
//    defined   : 32-bit frame counter readable at 0x40, cleared by any write
//    undefined : 0x40 reads 0, no counter logic
//
//  Ports
//    ACLK           sole clock
//    ARESETN        asynchronous active-low reset
//    bus            host register bus (slave modport)
//    DSP_VSYNC_X    async active-low vertical sync from the pixel domain
//    FIFO_OVER_IN   async FIFO overflow level
//    FIFO_UNDER_IN  async FIFO underflow level
//    DISPON         display enable
//    RESOL          resolution code
//    DISPADDR_ACT   active frame base address
//    PAGE_IDX       current page index
//    FRAME_START    one-cycle pulse per frame start
//    DSP_IRQ        active-high interrupt level
//
//  Register map
//    0x00 DISPADDR   0x04 DISPCTRL (b0 DISPON, b1 VBLANK w1c, b5:4 RESOL,
//    b8 AUTOFLIP)    0x08 DISPINT (b0 INTENBL, b1 pending w1c)
//    0x0C DISPFIFO (b0 OVER w1c, b1 UNDER w1c)   0x10+4k PAGEADDR[k]
// ============================================================================
module disp_regctrl_mp #(
  parameter int         NUM_PAGES   = 4,
  parameter int         SYNC_STAGES = 2,
  parameter logic [1:0] RESOL_RST   = 2'b00,
  localparam int        PW          = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  disp_regctrl_mp_if.slave   bus,
  input  logic               DSP_VSYNC_X,
  input  logic               FIFO_OVER_IN,
  input  logic               FIFO_UNDER_IN,
  output logic               DISPON,
  output logic [1:0]         RESOL,
  output logic [31:0]        DISPADDR_ACT,
  output logic [PW-1:0]      PAGE_IDX,
  output logic               FRAME_START,
  output logic               DSP_IRQ
);

  // Control/status registers
  logic [31:0]            r_dispaddr;
  logic                   r_dispon;
  logic                   r_vblank;
  logic [1:0]             r_resol;
  logic                   r_autoflip;
  logic                   r_inten;
  logic                   r_pend;
  logic                   r_over;
  logic                   r_under;
  logic [31:0]            r_pageaddr [NUM_PAGES];
  logic [PW-1:0]          r_page_idx;
  logic [31:0]            r_act;
  logic                   r_fs;
  logic                   r_irq;
  logic [31:0]            r_rdata;

  // Synchronisers
  logic [SYNC_STAGES-1:0] r_vs_sync;
  logic [SYNC_STAGES-1:0] r_ov_sync;
  logic [SYNC_STAGES-1:0] r_un_sync;
  logic                   r_vs_d;

  logic                   w_vs_s;
  logic                   w_ov_s;
  logic                   w_un_s;
  logic                   w_fs;
  logic                   w_wr_addr;
  logic                   w_wr_ctrl;
  logic                   w_wr_int;
  logic                   w_wr_fifo;
  logic [NUM_PAGES-1:0]   w_wr_page;
  logic [PW-1:0]          w_idx_inc;
  logic                   w_inten_nxt;
  logic                   w_pend_nxt;
  logic [31:0]            w_rd;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  // --------------------------------------------------------------------------
  // Asynchronous status inputs; chains clear to 0 on reset so a vsync that is
  // high at release produces a rising (ignored) edge, never a falling one.
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_vs_sync <= '0;
      r_ov_sync <= '0;
      r_un_sync <= '0;
      r_vs_d    <= 1'b0;
    end else begin
      r_vs_sync <= {r_vs_sync[SYNC_STAGES-2:0], DSP_VSYNC_X};
      r_ov_sync <= {r_ov_sync[SYNC_STAGES-2:0], FIFO_OVER_IN};
      r_un_sync <= {r_un_sync[SYNC_STAGES-2:0], FIFO_UNDER_IN};
      r_vs_d    <= w_vs_s;
    end
  end

  assign w_vs_s = r_vs_sync[SYNC_STAGES-1];
  assign w_ov_s = r_ov_sync[SYNC_STAGES-1];
  assign w_un_s = r_un_sync[SYNC_STAGES-1];
  assign w_fs   = r_vs_d & ~w_vs_s;

  // Write decode
  assign w_wr_addr = bus.WREN && (bus.WRADDR == 16'h0000);
  assign w_wr_ctrl = bus.WREN && (bus.WRADDR == 16'h0004);
  assign w_wr_int  = bus.WREN && (bus.WRADDR == 16'h0008);
  assign w_wr_fifo = bus.WREN && (bus.WRADDR == 16'h000C);

  genvar k;
  generate
    for (k = 0; k < NUM_PAGES; k++) begin : g_page_dec
      assign w_wr_page[k] = bus.WREN && (bus.WRADDR == 16'(16 + 4*k));
    end
  endgenerate

  assign w_idx_inc = (r_page_idx == PW'(NUM_PAGES - 1)) ? '0 : r_page_idx + 1'b1;

  // Pending/enable next-state so the IRQ register tracks them without an
  // extra cycle of lag; a frame-start set beats a same-cycle clear.
  assign w_inten_nxt = (w_wr_int & bus.BYTEEN[0]) ? bus.WDATA[0] : r_inten;
  assign w_pend_nxt  = (w_fs & r_inten) |
                       (r_pend & ~(w_wr_int & bus.BYTEEN[0] & bus.WDATA[1]));

`ifdef DISP_FRAMECNT_EN
  logic [31:0] r_framecnt;
  logic        w_wr_fcnt;

  assign w_wr_fcnt = bus.WREN && (bus.WRADDR == 16'h0040);

  // A write always wins over a same-cycle increment.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)       r_framecnt <= '0;
    else if (w_wr_fcnt) r_framecnt <= '0;
    else if (w_fs)      r_framecnt <= r_framecnt + 32'd1;
  end
`endif

  // --------------------------------------------------------------------------
  // Register file and frame-start actions. Frame-start uses the pre-write
  // values of DISPADDR/PAGEADDR/AUTOFLIP/INTENBL.
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_dispaddr <= '0;
      r_dispon   <= 1'b0;
      r_vblank   <= 1'b0;
      r_resol    <= RESOL_RST;
      r_autoflip <= 1'b0;
      r_inten    <= 1'b0;
      r_pend     <= 1'b0;
      r_over     <= 1'b0;
      r_under    <= 1'b0;
      r_page_idx <= '0;
      r_act      <= '0;
      r_fs       <= 1'b0;
      r_irq      <= 1'b0;
      for (int p = 0; p < NUM_PAGES; p++) r_pageaddr[p] <= '0;
    end else begin
      if (w_wr_addr) r_dispaddr <= f_merge(r_dispaddr, bus.WDATA, bus.BYTEEN);

      if (w_wr_ctrl & bus.BYTEEN[0]) begin
        r_dispon <= bus.WDATA[0];
        r_resol  <= bus.WDATA[5:4];
      end
      if (w_wr_ctrl & bus.BYTEEN[1]) r_autoflip <= bus.WDATA[8];

      for (int p = 0; p < NUM_PAGES; p++) begin
        if (w_wr_page[p]) r_pageaddr[p] <= f_merge(r_pageaddr[p], bus.WDATA, bus.BYTEEN);
      end

      // Sticky bits: set has priority over write-1-clear
      r_vblank <= w_fs   | (r_vblank & ~(w_wr_ctrl & bus.BYTEEN[0] & bus.WDATA[1]));
      r_over   <= w_ov_s | (r_over   & ~(w_wr_fifo & bus.BYTEEN[0] & bus.WDATA[0]));
      r_under  <= w_un_s | (r_under  & ~(w_wr_fifo & bus.BYTEEN[0] & bus.WDATA[1]));

      r_inten <= w_inten_nxt;
      r_pend  <= w_pend_nxt;
      r_irq   <= w_pend_nxt & w_inten_nxt;
      r_fs    <= w_fs;

      if (w_fs) begin
        if (r_autoflip) begin
          r_page_idx <= w_idx_inc;
          r_act      <= r_pageaddr[w_idx_inc];
        end else begin
          r_act      <= r_dispaddr;
        end
      end
    end
  end

  // Read mux: current (pre-write) register contents
  always_comb begin
    w_rd = '0;
    case (bus.RDADDR)
      16'h0000: w_rd = r_dispaddr;
      16'h0004: w_rd = {23'd0, r_autoflip, 2'b00, r_resol, 2'b00, r_vblank, r_dispon};
      16'h0008: w_rd = {30'd0, r_pend, r_inten};
      16'h000C: w_rd = {30'd0, r_under, r_over};
`ifdef DISP_FRAMECNT_EN
      16'h0040: w_rd = r_framecnt;
`endif
      default:  w_rd = '0;
    endcase
    for (int p = 0; p < NUM_PAGES; p++) begin
      if (bus.RDADDR == 16'(16 + 4*p)) w_rd = r_pageaddr[p];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)      r_rdata <= '0;
    else if (bus.RDEN) r_rdata <= w_rd;
  end

  assign bus.RDATA    = r_rdata;
  assign DISPON       = r_dispon;
  assign RESOL        = r_resol;
  assign DISPADDR_ACT = r_act;
  assign PAGE_IDX     = r_page_idx;
  assign FRAME_START  = r_fs;
  assign DSP_IRQ      = r_irq;

endmodule
`default_nettype wire
